// File: rtl/flasher_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : flasher_sequencer
//  Description : Runs N flick/observe cycles on the bound lamp flasher and
//                reports done / aborted / timeout to the host.
//  Revision    : 1.0  initial release
// ============================================================================
module flasher_sequencer #(
    parameter int LAMP_W = 16,
    parameter int REP_W  = 4,
    parameter int TO_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [REP_W-1:0]  cmd_reps,
    input  logic              cmd_abort,
    input  logic [LAMP_W-1:0] lamp_in,
    output logic              fl_flick,
    output logic              fl_hold,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err_to,
    output logic [REP_W-1:0]  reps_done
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_KICK     = 3'd1;
    localparam logic [2:0] c_WAIT_ON  = 3'd2;
    localparam logic [2:0] c_WAIT_OFF = 3'd3;
    localparam logic [2:0] c_GAP      = 3'd4;
    localparam logic [2:0] c_FIN      = 3'd5;

    localparam logic [TO_W-1:0] c_TO_MAX = '1;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [REP_W-1:0] r_reps;
    logic [TO_W-1:0]  r_to_cnt;
    logic [REP_W-1:0] w_rd_inc;
    logic             w_accept;
    logic             w_abort;
    logic             w_to_hit;
    logic             w_lamp_on;
    logic             w_waiting;

    assign cmd_ready = (r_state == c_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_rd_inc  = reps_done + 1'b1;
    assign w_to_hit  = (r_to_cnt == c_TO_MAX);
    assign w_lamp_on = (lamp_in != '0);
    assign w_waiting = (r_state == c_WAIT_ON) || (r_state == c_WAIT_OFF);
    // FIN already signals done, so an abort there just lets it finish.
    assign w_abort   = cmd_abort && (r_state != c_IDLE) && (r_state != c_FIN);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:     if (w_accept) w_next = (cmd_reps == '0) ? c_FIN : c_KICK;
            c_KICK:     w_next = c_WAIT_ON;
            c_WAIT_ON: begin
                if (w_to_hit)       w_next = c_IDLE;
                else if (w_lamp_on) w_next = c_WAIT_OFF;
            end
            c_WAIT_OFF: begin
                if (w_to_hit)        w_next = c_IDLE;
                else if (!w_lamp_on) w_next = (w_rd_inc == r_reps) ? c_FIN : c_GAP;
            end
            c_GAP:      w_next = c_KICK;
            c_FIN:      w_next = c_IDLE;
            default:    w_next = c_IDLE;
        endcase
        if (w_abort) w_next = c_IDLE;
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_reps    <= '0;
            r_to_cnt  <= '0;
            reps_done <= '0;
            err_to    <= 1'b0;
            aborted   <= 1'b0;
            fl_hold   <= 1'b1;
            fl_flick  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state  <= w_next;
            fl_hold  <= !((w_next == c_KICK) || (w_next == c_WAIT_ON) ||
                          (w_next == c_WAIT_OFF));
            fl_flick <= (w_next == c_KICK);
            busy     <= (w_next != c_IDLE);
            done     <= (w_next == c_FIN);
            aborted  <= w_abort;

            if (w_accept) begin
                r_reps    <= cmd_reps;
                reps_done <= '0;
                err_to    <= 1'b0;
                r_to_cnt  <= '0;
            end else if (!w_abort) begin
                if (r_state == c_KICK) begin
                    r_to_cnt <= '0;
                end else if (w_waiting) begin
                    if (w_to_hit) begin
                        err_to <= 1'b1;
                    end else if ((r_state == c_WAIT_ON) && w_lamp_on) begin
                        r_to_cnt <= '0;
                    end else if ((r_state == c_WAIT_OFF) && !w_lamp_on) begin
                        reps_done <= w_rd_inc;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flasher_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flasher_sequencer
//  Description : Directed self-checking bench for flasher_sequencer with a
//                small behavioural flasher driving lamp_in.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flasher_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_reps = 4'd0;
    logic        cmd_abort = 1'b0;
    logic [15:0] lamp_in;
    logic        fl_flick, fl_hold, busy, done, aborted, err_to;
    logic [3:0]  reps_done;

    bit          model_en = 1'b1;
    logic [15:0] lamp_force = 16'h0000;
    int          fm = 0;
    int          checks = 0;
    int          errors = 0;

    flasher_sequencer #(.LAMP_W(16), .REP_W(4), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reps(cmd_reps), .cmd_abort(cmd_abort), .lamp_in(lamp_in),
        .fl_flick(fl_flick), .fl_hold(fl_hold), .busy(busy), .done(done),
        .aborted(aborted), .err_to(err_to), .reps_done(reps_done)
    );

    always #5 clk = ~clk;

    // Flasher: lamps light 2 clk after a flick, stay lit 4 clk, then go dark.
    always @(posedge clk) begin
        if (fl_hold)       fm <= 0;
        else if (fl_flick) fm <= 1;
        else if (fm != 0)  fm <= (fm == 6) ? 0 : fm + 1;
    end
    assign lamp_in = model_en ? ((fm >= 2 && fm <= 5) ? 16'h0180 : 16'h0000) : lamp_force;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_idle(output int dones, output int flicks, output bit ok);
        dones = 0; flicks = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done)     dones++;
            if (fl_flick) flicks++;
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b expected 0", cmd_ready); end
        checks++; if (fl_hold !== 1'b1) begin errors++; $display("FAIL rst_hold: got %0b expected 1", fl_hold); end
        rst = 1'b0;
        repeat (5) tick();
        checks++; if (fl_hold !== 1'b1) begin errors++; $display("FAIL idle_hold: got %0b expected 1", fl_hold); end
        checks++; if (fl_flick !== 1'b0) begin errors++; $display("FAIL idle_flick: got %0b expected 0", fl_flick); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %0b expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
        checks++; if ({done, aborted, err_to, reps_done} !== 7'd0) begin errors++; $display("FAIL idle_flags: got %0h expected 0", {done, aborted, err_to, reps_done}); end
    endtask

    task automatic test_reps3();
        int  flicks, dones, aborts, bad_gap;
        bit  prev_hold, ok;
        flicks = 0; dones = 0; aborts = 0; bad_gap = 0; prev_hold = 1'b1; ok = 1'b0;
        model_en = 1'b1;
        cmd_reps = 4'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (fl_flick !== 1'b1) begin errors++; $display("FAIL reps3_flick_latency: got %0b expected 1", fl_flick); end
        for (int i = 0; i < 300; i++) begin
            if (fl_flick) begin
                flicks++;
                if (!prev_hold) bad_gap++;
            end
            if (done)    dones++;
            if (aborted) aborts++;
            prev_hold = fl_hold;
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reps3_timeout_wait: got %0b expected 1", ok); end
        checks++; if (flicks != 3) begin errors++; $display("FAIL reps3_flicks: got %0d expected 3", flicks); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL reps3_gap: got %0d expected 0", bad_gap); end
        checks++; if (dones != 1) begin errors++; $display("FAIL reps3_done: got %0d expected 1", dones); end
        checks++; if (aborts != 0) begin errors++; $display("FAIL reps3_aborted: got %0d expected 0", aborts); end
        checks++; if (reps_done !== 4'd3) begin errors++; $display("FAIL reps3_count: got %0d expected 3", reps_done); end
        checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL reps3_err_to: got %0b expected 0", err_to); end
    endtask

    task automatic test_reps0();
        cmd_reps = 4'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reps0_done: got %0b expected 1", done); end
        checks++; if (fl_flick !== 1'b0) begin errors++; $display("FAIL reps0_flick: got %0b expected 0", fl_flick); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reps0_done_pulse: got %0b expected 0", done); end
        checks++; if ({busy, fl_flick} !== 2'b00) begin errors++; $display("FAIL reps0_idle: got %0b expected 0", {busy, fl_flick}); end
        checks++; if (reps_done !== 4'd0) begin errors++; $display("FAIL reps0_count: got %0d expected 0", reps_done); end
    endtask

    task automatic test_abort();
        int dones, flicks;
        bit ok;
        ok = 1'b0;
        cmd_reps = 4'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (lamp_in != 16'h0) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_lamp_wait: got %0b expected 1", ok); end
        tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %0b expected 1", aborted); end
        checks++; if ({busy, done, fl_hold} !== 3'b001) begin errors++; $display("FAIL abort_state: got %0b expected 001", {busy, done, fl_hold}); end
        checks++; if (reps_done !== 4'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", reps_done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %0b expected 1", cmd_ready); end
        cmd_reps = 4'd1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if ({aborted, fl_flick} !== 2'b01) begin errors++; $display("FAIL abort_reaccept: got %0b expected 01", {aborted, fl_flick}); end
        run_to_idle(dones, flicks, ok);
        checks++; if (!ok || dones != 1 || reps_done !== 4'd1) begin errors++; $display("FAIL abort_rerun: got ok=%0b done=%0d reps=%0d expected 1 1 1", ok, dones, reps_done); end
    endtask

    task automatic test_timeout();
        int  n, dones, flicks;
        bit  ok;
        n = 0; dones = 0; ok = 1'b0;
        model_en = 1'b0; lamp_force = 16'h0000;
        cmd_reps = 4'd1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        // KICK now; 16 WAIT_ON cycles (count 0..15) then IDLE with err_to.
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (done) dones++;
            if (err_to) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b expected 1", ok); end
        checks++; if (n != 17) begin errors++; $display("FAIL to_latency: got %0d expected 17", n); end
        checks++; if ({busy, fl_hold, dones != 0} !== 3'b010) begin errors++; $display("FAIL to_state: got %0b expected 010", {busy, fl_hold, dones != 0}); end
        checks++; if (reps_done !== 4'd0) begin errors++; $display("FAIL to_count: got %0d expected 0", reps_done); end
        model_en = 1'b1;
        cmd_reps = 4'd1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b expected 0", err_to); end
        run_to_idle(dones, flicks, ok);
        checks++; if (!ok || dones != 1 || err_to !== 1'b0) begin errors++; $display("FAIL to_rerun: got ok=%0b done=%0d err=%0b expected 1 1 0", ok, dones, err_to); end
    endtask

    task automatic test_rst_mid();
        bit ok;
        ok = 1'b0;
        cmd_reps = 4'd4; cmd_valid = 1'b1;
        tick();
        cmd_reps = 4'd0;    // held request while busy must be ignored
        for (int i = 0; i < 60; i++) begin
            if (reps_done == 4'd1) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (ok !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_rep1: got ok=%0b busy=%0b expected 1 1", ok, busy); end
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (lamp_in != 16'h0) begin ok = 1'b1; break; end
            tick();
        end
        tick();
        checks++; if (ok !== 1'b1 || reps_done !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL mid_ignore_cmd: got ok=%0b reps=%0d busy=%0b expected 1 1 1", ok, reps_done, busy); end
        rst = 1'b1; cmd_valid = 1'b0;
        tick();
        checks++; if ({fl_hold, fl_flick, busy, done, aborted, err_to} !== 6'b100000) begin errors++; $display("FAIL mid_rst_flags: got %b expected 100000", {fl_hold, fl_flick, busy, done, aborted, err_to}); end
        checks++; if (reps_done !== 4'd0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_count: got reps=%0d ready=%0b expected 0 0", reps_done, cmd_ready); end
        rst = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_release: got %0b expected 1", cmd_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reps3();
        tick();
        test_reps0();
        tick();
        test_abort();
        tick();
        test_timeout();
        tick();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
